// File: rtl/param_memory.sv
// Byte-strobed single-port RAM with 1- or 2-cycle pipelined reads.
// Define MEM_PARITY_EN to add per-word even parity and the par_inj port.
module param_memory #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int DEPTH      = 48,
   parameter int RD_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic                    rd_en,
`ifdef MEM_PARITY_EN
   input  logic                    par_inj,
`endif
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    rvalid,
   output logic                    rerr
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  in_rng;
   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] cur;
   logic [DATA_WIDTH-1:0] merged;
   logic                  wr_go;
   logic                  perr;

   // Full-width compare so out-of-range addresses never alias.
   always_comb begin
      in_rng = ({1'b0, addr} < DEPTH_L);
      idx    = addr[IDX_W-1:0];
      cur    = in_rng ? mem[idx] : '0;
      merged = cur;
      for (int b = 0; b < NB; b++) begin
         if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
      end
      wr_go  = wr_en && in_rng && (|wstrb);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem <= '{default: '0};
      end else if (wr_go) begin
         mem[idx] <= merged;
      end
   end

`ifdef MEM_PARITY_EN
   logic par [DEPTH];

   always_ff @(posedge clk) begin
      if (!reset) begin
         par <= '{default: 1'b0};
      end else if (wr_go) begin
         par[idx] <= (^merged) ^ par_inj;
      end
   end

   always_comb begin
      perr = 1'b0;
      if (in_rng) perr = ((^cur) != par[idx]);
   end
`else
   always_comb perr = 1'b0;
`endif

   logic                  v1;
   logic                  e1;
   logic [DATA_WIDTH-1:0] d1;

   // Data regs only load on a valid beat so rdata holds between reads.
   always_ff @(posedge clk) begin
      if (!reset) begin
         v1 <= 1'b0;
         e1 <= 1'b0;
         d1 <= '0;
      end else begin
         v1 <= rd_en;
         e1 <= rd_en && (!in_rng || perr);
         if (rd_en) d1 <= cur;
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  v2;
         logic                  e2;
         logic [DATA_WIDTH-1:0] d2;

         always_ff @(posedge clk) begin
            if (!reset) begin
               v2 <= 1'b0;
               e2 <= 1'b0;
               d2 <= '0;
            end else begin
               v2 <= v1;
               e2 <= e1;
               if (v1) d2 <= d1;
            end
         end

         assign rdata  = d2;
         assign rvalid = v2;
         assign rerr   = e2;
      end else begin : g_lat1
         assign rdata  = d1;
         assign rvalid = v1;
         assign rerr   = e1;
      end
   endgenerate

endmodule

// File: tb/tb_param_memory.sv
// Directed self-checking bench for param_memory.
// Runs at RD_LATENCY=2; parity checks need MEM_PARITY_EN.
module tb_param_memory;

   localparam int DW  = 32;
   localparam int AW  = 6;
   localparam int DEP = 48;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] addr;
   logic          wr_en;
   logic [3:0]    wstrb;
   logic [DW-1:0] wdata;
   logic          rd_en;
   logic          par_inj;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          rerr;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] exp_b2b [4];

   always #5 clk = ~clk;

   param_memory #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .DEPTH(DEP),
      .RD_LATENCY(LAT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .addr(addr),
      .wr_en(wr_en),
      .wstrb(wstrb),
      .wdata(wdata),
      .rd_en(rd_en),
`ifdef MEM_PARITY_EN
      .par_inj(par_inj),
`endif
      .rdata(rdata),
      .rvalid(rvalid),
      .rerr(rerr)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [3:0] s, input logic inj);
      @(negedge clk);
      addr    = a;
      wdata   = d;
      wstrb   = s;
      par_inj = inj;
      wr_en   = 1'b1;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      par_inj = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [AW-1:0] a,
                     input logic [DW-1:0] ed, input logic ee,
                     input logic dowr, input logic [DW-1:0] wd);
      @(negedge clk);
      addr  = a;
      rd_en = 1'b1;
      wr_en = dowr;
      wdata = wd;
      wstrb = 4'hF;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      wr_en = 1'b0;
      chk({tag, ".rv1"}, 64'(rvalid), 64'(LAT == 1));
      for (int k = 2; k <= LAT; k++) begin
         @(posedge clk);
         #1;
         chk({tag, ".rvk"}, 64'(rvalid), 64'(k == LAT));
      end
      chk({tag, ".data"}, 64'(rdata), 64'(ed));
      chk({tag, ".err"}, 64'(rerr), 64'(ee));
      @(posedge clk);
      #1;
      chk({tag, ".rv0"}, 64'(rvalid), 64'd0);
      chk({tag, ".err0"}, 64'(rerr), 64'd0);
      chk({tag, ".hold"}, 64'(rdata), 64'(ed));
   endtask

   initial begin
      reset   = 1'b0;
      addr    = 6'd10;
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wstrb   = 4'hF;
      wdata   = 32'hCAFE_F00D;
      par_inj = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.rvalid", 64'(rvalid), 64'd0);
      chk("rst.rdata", 64'(rdata), 64'd0);
      chk("rst.rerr", 64'(rerr), 64'd0);

      // First cycle out of reset carries a write.
      @(negedge clk);
      reset = 1'b1;
      rd_en = 1'b0;
      addr  = 6'd3;
      wdata = 32'hDEAD_BEEF;
      wstrb = 4'hF;
      wr_en = 1'b1;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      chk("first.rvalid", 64'(rvalid), 64'd0);

      rd("rd3", 6'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
      rd("rst_wr_ign", 6'd10, 32'h0, 1'b0, 1'b0, '0);

      wr(6'd5, 32'h1122_3344, 4'hF, 1'b0);
      wr(6'd5, 32'hAABB_CCDD, 4'h5, 1'b0);
      rd("strb", 6'd5, 32'h11BB_33DD, 1'b0, 1'b0, '0);

      wr(6'd3, 32'h0, 4'h0, 1'b0);
      rd("strb0", 6'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);

      wr(6'd50, 32'h5555_AAAA, 4'hF, 1'b0);
      rd("oob50", 6'd50, 32'h0, 1'b1, 1'b0, '0);
      rd("alias2", 6'd2, 32'h0, 1'b0, 1'b0, '0);
      rd("oob63", 6'd63, 32'h0, 1'b1, 1'b0, '0);
      wr(6'd47, 32'h4747_4747, 4'hF, 1'b0);
      rd("last47", 6'd47, 32'h4747_4747, 1'b0, 1'b0, '0);

      wr(6'd7, 32'h1, 4'hF, 1'b0);
      rd("rdfirst", 6'd7, 32'h1, 1'b0, 1'b1, 32'h2);
      rd("rdafter", 6'd7, 32'h2, 1'b0, 1'b0, '0);

      wr(6'd0, 32'hA0, 4'hF, 1'b0);
      wr(6'd1, 32'hB1, 4'hF, 1'b0);
      wr(6'd2, 32'hC2, 4'hF, 1'b0);
      exp_b2b[0] = 32'hA0;
      exp_b2b[1] = 32'hB1;
      exp_b2b[2] = 32'hC2;
      exp_b2b[3] = 32'hDEAD_BEEF;
      for (int e = 1; e <= 3 + LAT; e++) begin
         @(negedge clk);
         rd_en = (e <= 4);
         addr  = AW'(e - 1);
         @(posedge clk);
         #1;
         if (e >= LAT) begin
            chk("b2b.rv", 64'(rvalid), 64'd1);
            chk("b2b.data", 64'(rdata), 64'(exp_b2b[e-LAT]));
         end else begin
            chk("b2b.rv_early", 64'(rvalid), 64'd0);
         end
      end
      @(negedge clk);
      rd_en = 1'b0;
      @(posedge clk);
      #1;
      chk("b2b.end", 64'(rvalid), 64'd0);

      // Two reads in flight when reset hits.
      @(negedge clk);
      rd_en = 1'b1;
      addr  = 6'd0;
      @(posedge clk);
      @(negedge clk);
      addr  = 6'd1;
      @(posedge clk);
      @(negedge clk);
      rd_en = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("flush.rst_rv", 64'(rvalid), 64'd0);
      chk("flush.rst_rd", 64'(rdata), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         chk("flush.norv", 64'(rvalid), 64'd0);
      end
      rd("cleared", 6'd3, 32'h0, 1'b0, 1'b0, '0);

`ifdef MEM_PARITY_EN
      wr(6'd9, 32'h1234_5678, 4'hF, 1'b1);
      rd("par_bad", 6'd9, 32'h1234_5678, 1'b1, 1'b0, '0);
      wr(6'd9, 32'h1234_5678, 4'hF, 1'b0);
      rd("par_ok", 6'd9, 32'h1234_5678, 1'b0, 1'b0, '0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
